pipe_ctrl: RTL

- Central pipeline sequencer for the 5-stage core. It resolves EX-stage redirects (branch/jump), load-use hazards, multi-cycle EX operations and external bus-hold requests.
- It drives per-stage hold/flush controls for PC, IF/ID, ID/EX and EX/MEM.
- It sits between the EX stage, the ID stage, the PC register and the external bus master.

---
 rtl/pipe_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl - central sequencer for the 5-stage pipeline.
//
// Resolves EX-stage redirects, load-use hazards, multi-cycle EX operations and
// external bus-hold requests. It drives the per-stage hold/flush controls.
//
// Ports
//   clk, arst_n         core clock, asynchronous active-low reset
//   jump_flag_i/addr_i  EX redirect request and target
//   ex_*_i              EX instruction: load flag, reg-write flag, rd
//   id_rs*_i            ID instruction source registers and read enables
//   mc_req_i/done_i     multi-cycle unit request / one-cycle done pulse
//   bus_req_i           external master bus request (level)
//   mc_start_o/abort_o  one-cycle start / timeout-abort pulses to the MC unit
//   jump_o/jump_addr_o  PC redirect and target
//   hold_o              {id_ex, if_id, pc} stage hold
//   flush_o             {id_ex, if_id} bubble insert
//   ex_bubble_o         bubble into EX/MEM
//   bus_gnt_o           registered bus grant
//   err_o               sticky multi-cycle timeout flag
//   stall_cnt_o         saturating count of cycles with hold_o[0]=1
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_mem_r_ena_i,
  input  logic              ex_reg_w_ena_i,
  input  logic [4:0]        ex_rd_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_rs1_en_i,
  input  logic              id_rs2_en_i,
  input  logic              mc_req_i,
  input  logic              mc_done_i,
  input  logic              bus_req_i,
  output logic              mc_start_o,
  output logic              mc_abort_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [2:0]        hold_o,
  output logic [1:0]        flush_o,
  output logic              ex_bubble_o,
  output logic              bus_gnt_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    BUS_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              bus_gnt_q, bus_gnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              ld_use_s;
  logic              mc_start_s, mc_abort_s, jump_s, ex_bubble_s;
  logic [ADDR_W-1:0] jump_addr_s;
  logic [2:0]        hold_s;
  logic [1:0]        flush_s;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    ld_use_s = ex_mem_r_ena_i & ex_reg_w_ena_i & (ex_rd_i != 5'd0) &
               ((id_rs1_en_i & (id_rs1_i == ex_rd_i)) |
                (id_rs2_en_i & (id_rs2_i == ex_rd_i)));
  end

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    bus_gnt_d   = bus_gnt_q;
    err_d       = err_q;
    mc_start_s  = 1'b0;
    mc_abort_s  = 1'b0;
    jump_s      = 1'b0;
    jump_addr_s = '0;
    hold_s      = 3'b000;
    flush_s     = 2'b00;
    ex_bubble_s = 1'b0;
    case (state_q)
      RUN: begin
        if (jump_flag_i) begin
          jump_s      = 1'b1;
          jump_addr_s = jump_addr_i;
          flush_s     = 2'b11;
        end else if (mc_req_i) begin
          mc_start_s  = 1'b1;
          hold_s      = 3'b111;
          ex_bubble_s = 1'b1;
          to_cnt_d    = '0;
          state_d     = MC_WAIT;
        end else if (ld_use_s) begin
          hold_s  = 3'b011;
          flush_s = 2'b10;
        end else if (bus_req_i) begin
          hold_s      = 3'b111;
          ex_bubble_s = 1'b1;
          bus_gnt_d   = 1'b1;
          state_d     = BUS_HOLD;
        end else begin
          state_d = RUN;
        end
      end
      MC_WAIT: begin
        // Done wins over a coincident timeout; the EX result then advances.
        if (mc_done_i) begin
          state_d = RUN;
        end else if (to_cnt_q == TO_LAST) begin
          mc_abort_s  = 1'b1;
          ex_bubble_s = 1'b1;
          err_d       = 1'b1;
          state_d     = RUN;
        end else begin
          hold_s      = 3'b111;
          ex_bubble_s = 1'b1;
          to_cnt_d    = to_cnt_q + TO_W'(1);
        end
      end
      BUS_HOLD: begin
        // Holds release in the same cycle the request drops.
        if (bus_req_i) begin
          hold_s      = 3'b111;
          ex_bubble_s = 1'b1;
        end else begin
          bus_gnt_d = 1'b0;
          state_d   = RUN;
        end
      end
      default: begin
        bus_gnt_d = 1'b0;
        state_d   = RUN;
      end
    endcase
  end

  // Saturating stall counter, advanced by the PC hold.
  always_comb begin
    if (hold_s[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, timeout counter, grant, sticky error and stall counter registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      bus_gnt_q   <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      bus_gnt_q   <= bus_gnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is asserted the controls show idle values whatever the inputs.
  always_comb begin
    if (arst_n) begin
      mc_start_o  = mc_start_s;
      mc_abort_o  = mc_abort_s;
      jump_o      = jump_s;
      jump_addr_o = jump_addr_s;
      hold_o      = hold_s;
      flush_o     = flush_s;
      ex_bubble_o = ex_bubble_s;
    end else begin
      mc_start_o  = 1'b0;
      mc_abort_o  = 1'b0;
      jump_o      = 1'b0;
      jump_addr_o = '0;
      hold_o      = 3'b000;
      flush_o     = 2'b00;
      ex_bubble_o = 1'b0;
    end
  end

  assign bus_gnt_o   = bus_gnt_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
